bit_serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor: one full-adder cell (two `half_adder` instances) plus a carry flip-flop processes a WIDTH-bit operand pair LSB-first, one bit per clock. It is the sequential, area-minimal successor to the combinational half/full-adder blocks. Built for low-gate-count datapaths where latency of WIDTH cycles is acceptable. Start/busy/done handshake; results held stable until the next operation.

---
 rtl/adder_pkg.sv | 11 +
 rtl/full_adder.sv | 17 +
 rtl/half_adder.sv | 13 +
 rtl/bit_serial_addsub.sv | 78 +++++++
 tb/tb_bit_serial_addsub.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state encoding and constant-width helper for the adder blocks.
//   state_t : IDLE=0, RUN=1, DONE=2
//   clog2   : ceiling log2, used to size counters at elaboration time
package adder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder built from two half adders and an OR.
//   a, b : input bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic s1, c1, c2;
   half_adder h0 (.a(a), .b(b), .s(s1), .c(c1));
   half_adder h1 (.a(s1), .b(cin), .s(s), .c(c2));
   assign cout = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder.
//   a, b : input bits
//   s    : sum bit
//   c    : carry bit
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/bit_serial_addsub.sv
// bit_serial_addsub: LSB-first bit-serial adder/subtractor, one bit per clock.
//   clk, rst_n        : clock, async active-low reset
//   start, sub, a, b  : request and operands, sampled in IDLE or DONE
//   busy              : high while computing
//   done              : one-cycle result-valid pulse
//   sum, carry_out,
//   overflow          : registered result, held until the next completion
module bit_serial_addsub
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);
   localparam int CW = clog2(WIDTH);
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] sh_a, sh_b, res, res_nxt;
   logic carry, s, cout, last, load;
   full_adder fa (.a(sh_a[0]), .b(sh_b[0]), .cin(carry), .s(s), .cout(cout));
   assign last    = cnt == CW'(WIDTH - 1);
   assign load    = start && state != RUN;
   assign res_nxt = {s, res[WIDTH-1:1]};
   assign busy    = state == RUN;
   assign done    = state == DONE;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = last ? DONE : RUN;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   // Subtraction is a + ~b + 1: invert b at load and seed the carry with 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sh_a      <= '0;
         sh_b      <= '0;
         res       <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (load) begin
         sh_a  <= a;
         sh_b  <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         sh_a  <= sh_a >> 1;
         sh_b  <= sh_b >> 1;
         res   <= res_nxt;
         carry <= cout;
         cnt   <= cnt + CW'(1);
         // On the MSB cycle, carry still holds the carry into the MSB.
         if (last) begin
            sum       <= res_nxt;
            carry_out <= cout;
            overflow  <= carry ^ cout;
         end
      end
   end
endmodule

// File: tb/tb_bit_serial_addsub.sv
// tb_bit_serial_addsub: randomized and directed self-checking bench for bit_serial_addsub (WIDTH 8 and 4).
module tb_bit_serial_addsub;
   logic clk = 1'b0;
   logic rst_n;
   logic start8, sub8, busy8, done8, co8, ov8;
   logic [7:0] a8, b8, sum8;
   logic start4, sub4, busy4, done4, co4, ov4;
   logic [3:0] a4, b4, sum4;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bit_serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
   );
   bit_serial_addsub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4), .overflow(ov4)
   );

   // Reference: plain modular and signed arithmetic on integers.
   function automatic void model(input int w, input int av, input int bv, input bit s,
                                 output int es, output bit ec, output bit eo);
      int mask, full, sa, sb, r;
      mask = (1 << w) - 1;
      full = av + (s ? ((~bv) & mask) + 1 : bv);
      es   = full & mask;
      ec   = ((full >> w) & 1) != 0;
      sa   = av >= (1 << (w - 1)) ? av - (1 << w) : av;
      sb   = bv >= (1 << (w - 1)) ? bv - (1 << w) : bv;
      r    = s ? sa - sb : sa + sb;
      eo   = r > (1 << (w - 1)) - 1 || r < -(1 << (w - 1));
   endfunction

   // Runs one WIDTH=8 op; optional start re-pulse in RUN cycle pulse_at+1.
   // Returns #1 after the edge that raises done.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit s, input int pulse_at);
      int es;
      bit ec, eo;
      logic [7:0] prev;
      model(8, int'(av), int'(bv), s, es, ec, eo);
      @(negedge clk);
      a8 = av; b8 = bv; sub8 = s; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      prev = sum8;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== prev) begin
            miscompares++;
            $display("FAIL run8 cycle %0d: busy=%b done=%b sum=%h, expected busy=1 done=0 sum=%h", i, busy8, done8, sum8, prev);
         end
         if (i == pulse_at) begin
            start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
         end
         @(posedge clk); #1;
         start8 = 1'b0;
      end
      vectors++;
      if (done8 !== 1'b1 || busy8 !== 1'b0) begin
         miscompares++;
         $display("FAIL done8 %h%s%h: done=%b busy=%b, expected done=1 busy=0", av, s ? "-" : "+", bv, done8, busy8);
      end
      vectors++;
      if (sum8 !== es[7:0] || co8 !== ec || ov8 !== eo) begin
         miscompares++;
         $display("FAIL result8 %h%s%h: sum=%h co=%b ov=%b, expected sum=%h co=%b ov=%b",
                  av, s ? "-" : "+", bv, sum8, co8, ov8, es[7:0], ec, eo);
      end
   endtask

   task automatic op4(input logic [3:0] av, input logic [3:0] bv, input bit s);
      int es;
      bit ec, eo;
      logic [3:0] prev;
      model(4, int'(av), int'(bv), s, es, ec, eo);
      @(negedge clk);
      a4 = av; b4 = bv; sub4 = s; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      prev = sum4;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (busy4 !== 1'b1 || done4 !== 1'b0 || sum4 !== prev) begin
            miscompares++;
            $display("FAIL run4 cycle %0d: busy=%b done=%b sum=%h, expected busy=1 done=0 sum=%h", i, busy4, done4, sum4, prev);
         end
         @(posedge clk); #1;
      end
      vectors++;
      if (done4 !== 1'b1 || busy4 !== 1'b0 || sum4 !== es[3:0] || co4 !== ec || ov4 !== eo) begin
         miscompares++;
         $display("FAIL result4 %h%s%h: done=%b busy=%b sum=%h co=%b ov=%b, expected done=1 busy=0 sum=%h co=%b ov=%b",
                  av, s ? "-" : "+", bv, done4, busy4, sum4, co4, ov4, es[3:0], ec, eo);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy8, done8, sum8, co8, ov8, busy4, done4, sum4, co4, ov4} !== '0) begin
         miscompares++;
         $display("FAIL reset: busy8=%b done8=%b sum8=%h co8=%b ov8=%b busy4=%b done4=%b sum4=%h, expected all 0",
                  busy8, done8, sum8, co8, ov8, busy4, done4, sum4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_directed();
      op8(8'h3C, 8'h05, 1'b0, -1);
      @(posedge clk); #1;
      vectors++;
      if (done8 !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse: done=%b one cycle after done, expected 0", done8);
      end
      op8(8'hFF, 8'h01, 1'b0, -1);
      op8(8'h7F, 8'h01, 1'b0, -1);
      op8(8'h05, 8'h07, 1'b1, -1);
      op8(8'h80, 8'h01, 1'b1, -1);
      op8(8'h00, 8'h00, 1'b1, -1);
      op8(8'h80, 8'h80, 1'b0, -1);
   endtask

   task automatic test_ignore_start();
      repeat (2) @(posedge clk);
      op8(8'h12, 8'h34, 1'b0, 2);
   endtask

   // Consecutive op8 calls assert start inside the DONE cycle of the previous op,
   // so each result must arrive exactly WIDTH+1 edges after the previous done.
   task automatic test_back_to_back();
      op8(8'hA5, 8'h5A, 1'b0, -1);
      op8(8'h33, 8'h44, 1'b1, -1);
      op8(8'hC0, 8'h40, 1'b1, -1);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a8 = 8'h6E; b8 = 8'h2B; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy8, done8, sum8, co8, ov8} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_run: busy=%b done=%b sum=%h co=%b ov=%b, expected all 0", busy8, done8, sum8, co8, ov8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL aborted_op cycle %0d: done=%b busy=%b, expected 0 0", i, done8, busy8);
         end
      end
      op8(8'h10, 8'h20, 1'b0, -1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         op8(8'($urandom), 8'($urandom), 1'($urandom), -1);
      end
   endtask

   task automatic test_exhaustive4();
      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               op4(4'(x), 4'(y), 1'(s));
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      test_exhaustive4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
